mips_controller: RTL and testbench

//  Single-cycle MIPS control decoder: maps opcode/funct of the current instruction to datapath controls.

---
 rtl/mips_ctrl_pkg.sv | 74 +++++++
 rtl/alu_decoder.sv | 40 ++++
 rtl/mips_controller.sv | 118 +++++++++++
 tb/tb_mips_controller.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the single-cycle MIPS control decoder: opcodes, R-type
// function codes, ALU operations, datapath mux selects and the control bundle.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_MFHI  = 6'b001010;
  localparam logic [5:0] FN_MFLO  = 6'b001011;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_XOR   = 6'b100110;
  localparam logic [5:0] FN_NOR   = 6'b100111;
  localparam logic [5:0] FN_XNOR  = 6'b101000;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_SLTU  = 6'b101011;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_XNOR = 4'b0100;
  localparam logic [3:0] ALU_NOR  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;

  localparam logic [1:0] ASRC_RT   = 2'b00;
  localparam logic [1:0] ASRC_SIMM = 2'b01;
  localparam logic [1:0] ASRC_ZIMM = 2'b10;
  localparam logic [1:0] ASRC_LUI  = 2'b11;

  localparam logic [1:0] RDST_RT = 2'b00;
  localparam logic [1:0] RDST_RD = 2'b01;
  localparam logic [1:0] RDST_RA = 2'b10;

  typedef struct packed {
    logic       multstart;
    logic       multsgn;
    logic       aluormult;
    logic       lohi;
    logic       regwrite;
    logic       memwrite;
    logic       memtoreg;
    logic [1:0] alusrc;
    logic [1:0] regdst;
    logic       jump;
    logic       jal;
    logic       bne;
    logic       branch;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/alu_decoder.sv
// ALU operation decoder: picks the 4-bit ALU operation from opcode, and from
// the function field for R-type instructions.
module alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] fn,
  output logic [3:0] alucontrol
);

  always_comb begin
    // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
    alucontrol = ALU_AND;
    case (op)
      OP_RTYPE: begin
        case (fn)
          FN_ADD, FN_ADDU: alucontrol = ALU_ADD;
          FN_SUB, FN_SUBU: alucontrol = ALU_SUB;
          FN_AND:          alucontrol = ALU_AND;
          FN_OR:           alucontrol = ALU_OR;
          FN_XOR:          alucontrol = ALU_XOR;
          FN_NOR:          alucontrol = ALU_NOR;
          FN_XNOR:         alucontrol = ALU_XNOR;
          FN_SLT:          alucontrol = ALU_SLT;
          FN_SLTU:         alucontrol = ALU_SLTU;
          default:         alucontrol = ALU_AND;
        endcase
      end
      OP_LW, OP_SW, OP_ADDI, OP_ADDIU: alucontrol = ALU_ADD;
      OP_BEQ, OP_BNE:                  alucontrol = ALU_SUB;
      OP_SLTI:                         alucontrol = ALU_SLT;
      OP_SLTIU:                        alucontrol = ALU_SLTU;
      OP_ANDI:                         alucontrol = ALU_AND;
      OP_ORI, OP_LUI:                  alucontrol = ALU_OR;
      OP_XORI:                         alucontrol = ALU_XOR;
      default:                         alucontrol = ALU_AND;
    endcase
  end

endmodule

// File: rtl/mips_controller.sv
// Single-cycle MIPS main control decoder. Purely combinational; reset forces
// every output low immediately, independent of the clock.
module mips_controller
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] fn,
  output logic       multstart,
  output logic       multsgn,
  output logic       aluormult,
  output logic       lohi,
  output logic       regwrite,
  output logic       memwrite,
  output logic       memtoreg,
  output logic [1:0] alusrc,
  output logic [1:0] regdst,
  output logic       jump,
  output logic       jal,
  output logic       bne,
  output logic       branch,
  output logic [3:0] alucontrol
);

  ctrl_t      ctrl;
  ctrl_t      ctrl_gated;
  logic [3:0] alu_op;

  // clk exists only for interface uniformity; nothing here is clocked.
  logic unused_clk;
  assign unused_clk = clk;

  alu_decoder u_alu_decoder (
    .op         (op),
    .fn         (fn),
    .alucontrol (alu_op)
  );

  always_comb begin
    ctrl = CTRL_NOP;
    case (op)
      OP_RTYPE: begin
        case (fn)
          FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_XOR,
          FN_NOR, FN_XNOR, FN_SLT, FN_SLTU: begin
            ctrl.regwrite = 1'b1;
            ctrl.regdst   = RDST_RD;
          end
          FN_MULT: begin
            ctrl.multstart = 1'b1;
            ctrl.multsgn   = 1'b1;
          end
          FN_MULTU: ctrl.multstart = 1'b1;
          FN_MFHI, FN_MFLO: begin
            ctrl.regwrite  = 1'b1;
            ctrl.regdst    = RDST_RD;
            ctrl.aluormult = 1'b1;
            ctrl.lohi      = (fn == FN_MFHI);
          end
          default: ctrl = CTRL_NOP;
        endcase
      end
      OP_LW: begin
        ctrl.regwrite = 1'b1;
        ctrl.memtoreg = 1'b1;
        ctrl.alusrc   = ASRC_SIMM;
      end
      OP_SW: begin
        ctrl.memwrite = 1'b1;
        ctrl.alusrc   = ASRC_SIMM;
      end
      OP_BEQ: ctrl.branch = 1'b1;
      OP_BNE: begin
        ctrl.branch = 1'b1;
        ctrl.bne    = 1'b1;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
        ctrl.regwrite = 1'b1;
        ctrl.alusrc   = ASRC_SIMM;
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        ctrl.regwrite = 1'b1;
        ctrl.alusrc   = ASRC_ZIMM;
      end
      OP_LUI: begin
        ctrl.regwrite = 1'b1;
        ctrl.alusrc   = ASRC_LUI;
      end
      OP_J: ctrl.jump = 1'b1;
      OP_JAL: begin
        ctrl.jump     = 1'b1;
        ctrl.jal      = 1'b1;
        ctrl.regwrite = 1'b1;
        ctrl.regdst   = RDST_RA;
      end
      default: ctrl = CTRL_NOP;
    endcase
  end

  assign ctrl_gated = reset ? CTRL_NOP : ctrl;

  assign multstart  = ctrl_gated.multstart;
  assign multsgn    = ctrl_gated.multsgn;
  assign aluormult  = ctrl_gated.aluormult;
  assign lohi       = ctrl_gated.lohi;
  assign regwrite   = ctrl_gated.regwrite;
  assign memwrite   = ctrl_gated.memwrite;
  assign memtoreg   = ctrl_gated.memtoreg;
  assign alusrc     = ctrl_gated.alusrc;
  assign regdst     = ctrl_gated.regdst;
  assign jump       = ctrl_gated.jump;
  assign jal        = ctrl_gated.jal;
  assign bne        = ctrl_gated.bne;
  assign branch     = ctrl_gated.branch;
  assign alucontrol = reset ? 4'b0000 : alu_op;

endmodule

// File: tb/tb_mips_controller.sv
// Directed bench for mips_controller: hand-checked instructions, reset gating,
// and full opcode / R-type function sweeps against an independent table.
module tb_mips_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic [5:0] fn;
  logic       multstart, multsgn, aluormult, lohi, regwrite, memwrite, memtoreg;
  logic [1:0] alusrc, regdst;
  logic       jump, jal, bne, branch;
  logic [3:0] alucontrol;

  int tests  = 0;
  int failed = 0;

  // Field order: multstart multsgn aluormult lohi regwrite memwrite memtoreg
  //              alusrc[1:0] regdst[1:0] jump jal bne branch alucontrol[3:0]
  logic [18:0] actual;
  assign actual = {multstart, multsgn, aluormult, lohi, regwrite, memwrite, memtoreg,
                   alusrc, regdst, jump, jal, bne, branch, alucontrol};

  mips_controller dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .fn         (fn),
    .multstart  (multstart),
    .multsgn    (multsgn),
    .aluormult  (aluormult),
    .lohi       (lohi),
    .regwrite   (regwrite),
    .memwrite   (memwrite),
    .memtoreg   (memtoreg),
    .alusrc     (alusrc),
    .regdst     (regdst),
    .jump       (jump),
    .jal        (jal),
    .bne        (bne),
    .branch     (branch),
    .alucontrol (alucontrol)
  );

  always #5 clk = ~clk;

  // Reference table written out as complete expected words per instruction.
  function automatic logic [18:0] ref_ctrl(input logic [5:0] o, input logic [5:0] f);
    logic [18:0] v;
    v = 19'b0;
    case (o)
      6'b000000: begin
        case (f)
          6'b100000, 6'b100001: v = 19'b0000_100_00_01_0000_0010;
          6'b100010, 6'b100011: v = 19'b0000_100_00_01_0000_0110;
          6'b100100:            v = 19'b0000_100_00_01_0000_0000;
          6'b100101:            v = 19'b0000_100_00_01_0000_0001;
          6'b100110:            v = 19'b0000_100_00_01_0000_0011;
          6'b100111:            v = 19'b0000_100_00_01_0000_0101;
          6'b101000:            v = 19'b0000_100_00_01_0000_0100;
          6'b101010:            v = 19'b0000_100_00_01_0000_0111;
          6'b101011:            v = 19'b0000_100_00_01_0000_1000;
          6'b011000:            v = 19'b1100_000_00_00_0000_0000;
          6'b011001:            v = 19'b1000_000_00_00_0000_0000;
          6'b001010:            v = 19'b0011_100_00_01_0000_0000;
          6'b001011:            v = 19'b0010_100_00_01_0000_0000;
          default:              v = 19'b0;
        endcase
      end
      6'b100011: v = 19'b0000_101_01_00_0000_0010;
      6'b101011: v = 19'b0000_010_01_00_0000_0010;
      6'b000100: v = 19'b0000_000_00_00_0001_0110;
      6'b000101: v = 19'b0000_000_00_00_0011_0110;
      6'b001000,
      6'b001001: v = 19'b0000_100_01_00_0000_0010;
      6'b001010: v = 19'b0000_100_01_00_0000_0111;
      6'b001011: v = 19'b0000_100_01_00_0000_1000;
      6'b001100: v = 19'b0000_100_10_00_0000_0000;
      6'b001101: v = 19'b0000_100_10_00_0000_0001;
      6'b001110: v = 19'b0000_100_10_00_0000_0011;
      6'b001111: v = 19'b0000_100_11_00_0000_0001;
      6'b000010: v = 19'b0000_000_00_00_1000_0000;
      6'b000011: v = 19'b0000_100_00_10_1100_0000;
      default:   v = 19'b0;
    endcase
    return v;
  endfunction

  // Change inputs just after a rising edge, sample on the following falling edge.
  task automatic apply(input logic [5:0] o, input logic [5:0] f);
    @(posedge clk);
    #1;
    op = o;
    fn = f;
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    apply(6'b100011, 6'b000000);
    tests++;
    if (actual !== 19'b0) begin
      failed++;
      $display("FAIL reset_lw: got %b expected %b", actual, 19'b0);
    end
    // Deassert mid-cycle: lw controls appear without a clock edge.
    #1 reset = 1'b0;
    #1;
    tests++;
    if (actual !== 19'b0000_101_01_00_0000_0010) begin
      failed++;
      $display("FAIL reset_release: got %b expected %b", actual, 19'b0000_101_01_00_0000_0010);
    end
    // Reassert mid-cycle: outputs drop immediately.
    #1 reset = 1'b1;
    #1;
    tests++;
    if (actual !== 19'b0) begin
      failed++;
      $display("FAIL reset_async: got %b expected %b", actual, 19'b0);
    end
    reset = 1'b0;
  endtask

  task automatic test_nop;
    apply(6'b000000, 6'b000000);
    tests++;
    if (actual !== 19'b0) begin
      failed++;
      $display("FAIL nop_sll: got %b expected %b", actual, 19'b0);
    end
  endtask

  task automatic test_branch;
    apply(6'b000100, 6'b000000);
    tests++;
    if ({branch, bne, alucontrol, regwrite} !== {1'b1, 1'b0, 4'b0110, 1'b0}) begin
      failed++;
      $display("FAIL beq: got br=%b bne=%b alu=%b rw=%b expected 1 0 0110 0",
               branch, bne, alucontrol, regwrite);
    end
    apply(6'b000101, 6'b000000);
    tests++;
    if ({branch, bne} !== 2'b11) begin
      failed++;
      $display("FAIL bne: got br=%b bne=%b expected 1 1", branch, bne);
    end
  endtask

  task automatic test_itype;
    apply(6'b001111, 6'b000000);
    tests++;
    if ({regwrite, alusrc, regdst} !== {1'b1, 2'b11, 2'b00}) begin
      failed++;
      $display("FAIL lui: got rw=%b asrc=%b rdst=%b expected 1 11 00", regwrite, alusrc, regdst);
    end
    apply(6'b001110, 6'b000000);
    tests++;
    if ({alusrc, alucontrol} !== {2'b10, 4'b0011}) begin
      failed++;
      $display("FAIL xori: got asrc=%b alu=%b expected 10 0011", alusrc, alucontrol);
    end
  endtask

  task automatic test_rtype;
    apply(6'b000000, 6'b101000);
    tests++;
    if ({regwrite, regdst, alucontrol} !== {1'b1, 2'b01, 4'b0100}) begin
      failed++;
      $display("FAIL xnor: got rw=%b rdst=%b alu=%b expected 1 01 0100", regwrite, regdst, alucontrol);
    end
    apply(6'b000000, 6'b011000);
    tests++;
    if ({multstart, multsgn, regwrite} !== 3'b110) begin
      failed++;
      $display("FAIL mult: got ms=%b sg=%b rw=%b expected 1 1 0", multstart, multsgn, regwrite);
    end
    apply(6'b000000, 6'b001010);
    tests++;
    if ({aluormult, lohi, regwrite} !== 3'b111) begin
      failed++;
      $display("FAIL mfhi: got am=%b lohi=%b rw=%b expected 1 1 1", aluormult, lohi, regwrite);
    end
  endtask

  task automatic test_jump;
    apply(6'b000011, 6'b000000);
    tests++;
    if ({jump, jal, regwrite, regdst} !== {1'b1, 1'b1, 1'b1, 2'b10}) begin
      failed++;
      $display("FAIL jal: got j=%b jal=%b rw=%b rdst=%b expected 1 1 1 10", jump, jal, regwrite, regdst);
    end
  endtask

  task automatic test_sweep_ops;
    int bad_excl;
    bad_excl = 0;
    for (int i = 0; i < 64; i++) begin
      // fn=100101 (or) must be ignored for every op other than R-type.
      apply(i[5:0], 6'b100101);
      tests++;
      if (actual !== ref_ctrl(i[5:0], 6'b100101)) begin
        failed++;
        $display("FAIL op_sweep op=%b: got %b expected %b", i[5:0], actual, ref_ctrl(i[5:0], 6'b100101));
      end
      if (memwrite && regwrite) bad_excl++;
    end
    tests++;
    if (bad_excl != 0) begin
      failed++;
      $display("FAIL op_sweep_mem_reg_excl: got %0d conflicts expected 0", bad_excl);
    end
  endtask

  task automatic test_sweep_fns;
    int bad_excl;
    bad_excl = 0;
    for (int i = 0; i < 64; i++) begin
      apply(6'b000000, i[5:0]);
      tests++;
      if (actual !== ref_ctrl(6'b000000, i[5:0])) begin
        failed++;
        $display("FAIL fn_sweep fn=%b: got %b expected %b", i[5:0], actual, ref_ctrl(6'b000000, i[5:0]));
      end
      if (memwrite && regwrite) bad_excl++;
    end
    tests++;
    if (bad_excl != 0) begin
      failed++;
      $display("FAIL fn_sweep_mem_reg_excl: got %0d conflicts expected 0", bad_excl);
    end
  endtask

  initial begin
    reset = 1'b1;
    op    = 6'b000000;
    fn    = 6'b000000;
    test_reset();
    test_nop();
    test_branch();
    test_itype();
    test_rtype();
    test_jump();
    test_sweep_ops();
    test_sweep_fns();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
